matriz_ctrl: RTL and testbench

Frame-buffer controller for the 5×7 LED matrix column scanner. A client writes column patterns into a back buffer through a valid/ready port and then requests a commit. The block copies the back buffer into the front buffer only at a scan-frame boundary, so the scanner never displays a torn frame. The front buffer drives the scanner's five column-pattern inputs directly, and the block monitors the scanner's column-select output to find frame boundaries.

---
 rtl/matriz_pkg.sv | 22 ++
 rtl/matriz_blink.sv | 39 +++
 rtl/matriz_ctrl.sv | 134 +++++++++++++
 tb/tb_matriz_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared types and constants for the 5x7 LED matrix frame-buffer controller.
// Optional blink support is enabled with MATRIZ_CTRL_BLINK_EN (see matriz_ctrl).
package matriz_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;

  localparam logic [NUM_COLS-1:0] FRAME_END = 5'b10000;

  typedef enum logic {IDLE, PENDING} state_t;

  typedef logic [2:0]          col_idx_t;
  typedef logic [NUM_ROWS-1:0] row_pat_t;

  localparam col_idx_t LAST_COL = col_idx_t'(NUM_COLS - 1);

  // Only the exact last-column pattern marks a frame end; any non-one-hot value never matches.
  function automatic logic isFrameEnd(input logic [NUM_COLS-1:0] mon);
    return mon == FRAME_END;
  endfunction

endpackage

// File: rtl/matriz_blink.sv
// Blink phase generator: counts scan frames and flips the display phase every BLINK_DIV frames.
// Instantiated by matriz_ctrl only when MATRIZ_CTRL_BLINK_EN is defined.
module matriz_blink #(
  parameter int BLINK_DIV = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic frameEnd_i,
  input  logic blinkOn_i,
  output logic phaseOn_o
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] frameCnt_q;
  logic          phaseOn_q;

  // With blinking disabled the phase is pinned on so re-enabling always starts visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frameCnt_q <= '0;
      phaseOn_q  <= 1'b1;
    end else if (!blinkOn_i) begin
      frameCnt_q <= '0;
      phaseOn_q  <= 1'b1;
    end else if (frameEnd_i) begin
      if (frameCnt_q == CNT_LAST) begin
        frameCnt_q <= '0;
        phaseOn_q  <= ~phaseOn_q;
      end else begin
        frameCnt_q <= frameCnt_q + CW'(1);
      end
    end
  end

  assign phaseOn_o = phaseOn_q;

endmodule

// File: rtl/matriz_ctrl.sv
// Double-buffered frame store for the 5x7 column scanner; back buffer is published at frame ends.
// Define MATRIZ_CTRL_BLINK_EN to add frame-synchronous blinking of the outputs.
module matriz_ctrl
  import matriz_pkg::*;
#(
  parameter int TIMEOUT   = 1023,
  parameter int BLINK_DIV = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  col_idx_t            wr_col,
  input  row_pat_t            wr_data,
  input  logic                commit,
  output logic                commit_pending,
  output logic                swap_done,
  output logic                swap_forced,
  output logic                wr_err,
  input  logic [NUM_COLS-1:0] colunas_mon,
  input  logic                blink_on,
  output row_pat_t            coluna1,
  output row_pat_t            coluna2,
  output row_pat_t            coluna3,
  output row_pat_t            coluna4,
  output row_pat_t            coluna5
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q;
  logic [TW-1:0] timer_q;
  row_pat_t      back_q  [NUM_COLS];
  row_pat_t      front_q [NUM_COLS];
  logic          wrReady_q;
  logic          commitPending_q;
  logic          swapDone_q;
  logic          swapForced_q;
  logic          wrErr_q;

  logic frameEnd;
  logic timeoutHit;
  logic blank;

  assign frameEnd   = isFrameEnd(colunas_mon);
  assign timeoutHit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

  // A boundary that coincides with the timeout is reported as an ordinary boundary swap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      wrReady_q       <= 1'b1;
      commitPending_q <= 1'b0;
      swapDone_q      <= 1'b0;
      swapForced_q    <= 1'b0;
      wrErr_q         <= 1'b0;
      for (int k = 0; k < NUM_COLS; k++) begin
        back_q[k]  <= '0;
        front_q[k] <= '0;
      end
    end else begin
      swapDone_q   <= 1'b0;
      swapForced_q <= 1'b0;
      wrErr_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_valid) begin
            if (wr_col > LAST_COL) begin
              wrErr_q <= 1'b1;
            end
            for (int k = 0; k < NUM_COLS; k++) begin
              if (wr_col == col_idx_t'(k)) back_q[k] <= wr_data;
            end
          end
          if (commit) begin
            state_q         <= PENDING;
            timer_q         <= '0;
            wrReady_q       <= 1'b0;
            commitPending_q <= 1'b1;
          end
        end
        PENDING: begin
          if (frameEnd || timeoutHit) begin
            for (int k = 0; k < NUM_COLS; k++) front_q[k] <= back_q[k];
            swapDone_q      <= 1'b1;
            swapForced_q    <= !frameEnd;
            timer_q         <= '0;
            state_q         <= IDLE;
            wrReady_q       <= 1'b1;
            commitPending_q <= 1'b0;
          end else if (TIMEOUT != 0) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MATRIZ_CTRL_BLINK_EN
  logic phaseOn;

  matriz_blink #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clock      (clock),
    .reset      (reset),
    .frameEnd_i (frameEnd),
    .blinkOn_i  (blink_on),
    .phaseOn_o  (phaseOn)
  );

  assign blank = blink_on && !phaseOn;
`else
  logic unusedCfg;
  assign unusedCfg = blink_on ^ (BLINK_DIV == 0);
  assign blank     = 1'b0;
`endif

  assign wr_ready       = wrReady_q;
  assign commit_pending = commitPending_q;
  assign swap_done      = swapDone_q;
  assign swap_forced    = swapForced_q;
  assign wr_err         = wrErr_q;

  assign coluna1 = blank ? '0 : front_q[0];
  assign coluna2 = blank ? '0 : front_q[1];
  assign coluna3 = blank ? '0 : front_q[2];
  assign coluna4 = blank ? '0 : front_q[3];
  assign coluna5 = blank ? '0 : front_q[4];

endmodule

// File: tb/tb_matriz_ctrl.sv
// Self-checking bench for matriz_ctrl: directed scenarios plus randomized traffic against a frame-level model.
// Blink behaviour is modelled when MATRIZ_CTRL_BLINK_EN is defined.
module tb_matriz_ctrl;
  import matriz_pkg::*;

  localparam int TIMEOUT   = 4;
  localparam int BLINK_DIV = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_col;
  logic [6:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic       swap_done;
  logic       swap_forced;
  logic       wr_err;
  logic [4:0] colunas_mon;
  logic       blink_on;
  logic [6:0] coluna1, coluna2, coluna3, coluna4, coluna5;

  int checks = 0;
  int passed = 0;

  logic [6:0] mBack  [5];
  logic [6:0] mFront [5];
  bit         mPending;
  int         mWait;
  bit         mDone, mForced, mErr;
  bit         mPhaseOn;
  int         mFrames;

  matriz_ctrl #(
    .TIMEOUT   (TIMEOUT),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_col         (wr_col),
    .wr_data        (wr_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .swap_done      (swap_done),
    .swap_forced    (swap_forced),
    .wr_err         (wr_err),
    .colunas_mon    (colunas_mon),
    .blink_on       (blink_on),
    .coluna1        (coluna1),
    .coluna2        (coluna2),
    .coluna3        (coluna3),
    .coluna4        (coluna4),
    .coluna5        (coluna5)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  function automatic void modelReset();
    for (int k = 0; k < 5; k++) begin
      mBack[k]  = '0;
      mFront[k] = '0;
    end
    mPending = 0; mWait = 0;
    mDone = 0; mForced = 0; mErr = 0;
    mPhaseOn = 1; mFrames = 0;
  endfunction

  // One clock edge of the controller described at the buffer/commit level.
  function automatic void modelStep();
    bit boundary;
    boundary = (colunas_mon == 5'b10000);
    mDone = 0; mForced = 0; mErr = 0;
    if (!mPending) begin
      if (wr_valid) begin
        if (wr_col < 5) mBack[wr_col] = wr_data;
        else mErr = 1;
      end
      if (commit) begin
        mPending = 1;
        mWait = 0;
      end
    end else begin
      mWait++;
      if (boundary || (TIMEOUT != 0 && mWait == TIMEOUT)) begin
        for (int k = 0; k < 5; k++) mFront[k] = mBack[k];
        mDone = 1;
        mForced = !boundary;
        mPending = 0;
      end
    end
`ifdef MATRIZ_CTRL_BLINK_EN
    if (!blink_on) begin
      mPhaseOn = 1;
      mFrames = 0;
    end else if (boundary) begin
      mFrames++;
      if (mFrames == BLINK_DIV) begin
        mFrames = 0;
        mPhaseOn = !mPhaseOn;
      end
    end
`endif
  endfunction

  task automatic compareAll();
    logic [6:0] obs [5];
    bit blank;
    obs = '{coluna1, coluna2, coluna3, coluna4, coluna5};
    blank = 0;
`ifdef MATRIZ_CTRL_BLINK_EN
    blank = blink_on && !mPhaseOn;
`endif
    checkOutput("wr_ready", wr_ready, !mPending);
    checkOutput("commit_pending", commit_pending, mPending);
    checkOutput("swap_done", swap_done, mDone);
    checkOutput("swap_forced", swap_forced, mForced);
    checkOutput("wr_err", wr_err, mErr);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("coluna%0d", k + 1), obs[k], blank ? 7'h00 : mFront[k]);
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [6:0] d,
                               input logic cm, input logic [4:0] mon, input logic bl);
    wr_valid = v; wr_col = c; wr_data = d; commit = cm; colunas_mon = mon; blink_on = bl;
    @(posedge clock);
    modelStep();
    #1;
    compareAll();
  endtask

  initial begin
    int n;
    int scanIdx;
    logic [4:0] mon;
    logic bl;

    reset = 1'b1; wr_valid = 0; wr_col = 0; wr_data = 0; commit = 0; colunas_mon = 0; blink_on = 0;
    modelReset();
    #12;
    compareAll();
    reset = 1'b0;

    // Fill all columns and commit; the 10000 edge coincides with the timeout and must count as a boundary.
    for (int c = 0; c < 5; c++)
      applyStimulus(1, 3'(c), 7'(7'h01 << c), 0, 5'(5'b00001 << c), 0);
    applyStimulus(0, 0, 0, 1, 5'b00001, 0);
    for (int c = 1; c < 5; c++)
      applyStimulus(0, 0, 0, 0, 5'(5'b00001 << c), 0);
    checkOutput("t1_swap_done", swap_done, 1);
    checkOutput("t1_swap_forced", swap_forced, 0);
    checkOutput("t1_coluna1", coluna1, 7'h01);
    checkOutput("t1_coluna2", coluna2, 7'h02);
    checkOutput("t1_coluna3", coluna3, 7'h04);
    checkOutput("t1_coluna4", coluna4, 7'h08);
    checkOutput("t1_coluna5", coluna5, 7'h10);

    // A write presented while pending must be refused.
    applyStimulus(0, 0, 0, 1, 5'b00001, 0);
    checkOutput("t2_ready_low", wr_ready, 0);
    applyStimulus(1, 2, 7'h7F, 0, 5'b00010, 0);
    applyStimulus(0, 0, 0, 0, 5'b00100, 0);
    applyStimulus(0, 0, 0, 0, 5'b10000, 0);
    checkOutput("t2_coluna3_kept", coluna3, 7'h04);

    // Scanner stalled: only the timeout can publish, 4 cycles after entering PENDING.
    applyStimulus(0, 0, 0, 1, 5'b00001, 0);
    n = 99;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 0, 0, 0, 5'b00001, 0);
      if (swap_done) begin
        n = i;
        break;
      end
    end
    checkOutput("t3_forced_latency", n, 4);
    checkOutput("t3_swap_forced", swap_forced, 1);

    // Illegal column, then write and commit in the same cycle.
    applyStimulus(1, 6, 7'h55, 0, 5'b00001, 0);
    checkOutput("t4_wr_err", wr_err, 1);
    applyStimulus(1, 0, 7'h33, 1, 5'b00010, 0);
    checkOutput("t4_wr_err_once", wr_err, 0);
    applyStimulus(0, 0, 0, 0, 5'b00100, 0);
    applyStimulus(0, 0, 0, 0, 5'b01000, 0);
    applyStimulus(0, 0, 0, 0, 5'b10000, 0);
    checkOutput("t4_coluna1", coluna1, 7'h33);
    checkOutput("t4_coluna2", coluna2, 7'h02);

    // Reset two cycles into PENDING aborts the commit.
    applyStimulus(1, 4, 7'h6A, 1, 5'b00001, 0);
    applyStimulus(0, 0, 0, 0, 5'b00010, 0);
    applyStimulus(0, 0, 0, 0, 5'b00100, 0);
    reset = 1'b1;
    #2;
    modelReset();
    compareAll();
    #2;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 5'b10000, 0);
    checkOutput("t5_no_swap", swap_done, 0);
    checkOutput("t5_coluna5", coluna5, 7'h00);

    // Randomized traffic with a mostly running scanner, stalls and glitches.
    scanIdx = 0;
    bl = 0;
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 9);
      if (n < 7) scanIdx = (scanIdx + 1) % 5;
      mon = 5'(5'b00001 << scanIdx);
      if (n == 8) mon = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) bl = !bl;
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom),
                    ($urandom_range(0, 5) == 0), mon, bl);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
